// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle and MUL is a shift-add loop; every output is registered.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               c_out,
  output logic               zero,
  output logic               ovf,
  output logic               busy
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] mult;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             add_ovf;
  logic [WIDTH-1:0] single_res;
  logic             single_c;
  logic             single_v;
  logic             is_shift;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] iter_res;

  // Shared adder: SUB and SLT both evaluate a + ~b + 1.
  always_comb begin
    if (op == OP_SUB || op == OP_SLT) begin
      add_b   = ~b;
      add_cin = 1'b1;
    end else begin
      add_b   = b;
      add_cin = 1'b0;
    end
    {carry, sum} = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_ovf = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Result and flags of ops that complete on the accept edge.
  always_comb begin
    single_res = ZERO_W;
    single_c   = 1'b0;
    single_v   = 1'b0;
    is_shift   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    case (op)
      OP_AND: single_res = a & b;
      OP_OR:  single_res = a | b;
      OP_ADD, OP_SUB: begin
        single_res = sum;
        single_c   = carry;
        single_v   = add_ovf;
      end
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_SLL, OP_SRL, OP_SRA: single_res = a;
      default: single_res = ZERO_W;
    endcase
  end

  // Next value of the iterative shifter and the multiplier accumulator.
  always_comb begin
    case (op_q)
      OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shift_next = work;
    endcase
    if (work[0]) begin
      acc_next = acc + mult;
    end else begin
      acc_next = acc;
    end
    if (state == ST_MUL) begin
      iter_res = acc_next;
    end else begin
      iter_res = shift_next;
    end
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= ZERO_W;
      c_out     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      op_q      <= 4'b0000;
      work      <= ZERO_W;
      mult      <= ZERO_W;
      acc       <= ZERO_W;
      cnt       <= {CNT_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (is_shift && shamt != {SHAMT_W{1'b0}}) begin
              work  <= a;
              cnt   <= {1'b0, shamt};
              state <= ST_SHIFT;
            end else if (op == OP_MUL) begin
              work  <= a;
              mult  <= b;
              acc   <= ZERO_W;
              cnt   <= CNT_W'(WIDTH);
              state <= ST_MUL;
            end else begin
              result    <= single_res;
              c_out     <= single_c;
              ovf       <= single_v;
              zero      <= (single_res == ZERO_W);
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT, ST_MUL: begin
          if (state == ST_SHIFT) begin
            work <= shift_next;
          end else begin
            acc  <= acc_next;
            mult <= {mult[WIDTH-2:0], 1'b0};
            work <= {1'b0, work[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          // The last iteration writes its value straight into the result register.
          if (cnt == CNT_W'(1)) begin
            result    <= iter_res;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= (iter_res == ZERO_W);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
